// File: rtl/cart_bus_ctrl.sv
// cart_bus_ctrl: bridges MMU cartridge accesses (ROM 0x0000-0x7FFF, external
// RAM 0xA000-0xBFFF) onto the Game Boy cartridge edge connector. This block
// runs the cartridge power-on reset sequence. It sequences the address and
// the /RD, /WR and /CS strobes, sets the data-bus direction, and divides
// clk down to make the cartridge PHI clock.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/req_we/req_addr/req_wdata/req_ready   MMU request handshake
//   rsp_valid/rsp_rdata                             one-cycle completion
//   cart_clk, cart_n_rst, cart_n_cs, cart_n_rd, cart_n_wr, cart_addr
//                                                   registered cartridge pins
//   cart_d_out/cart_d_oe/cart_d_in                  split tristate data bus
module cart_bus_ctrl #(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RST_CYC    = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        cart_clk,
  output logic        cart_n_rst,
  output logic        cart_n_cs,
  output logic        cart_n_rd,
  output logic        cart_n_wr,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_in
);

  localparam int MAX_SA = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int MAX_HR = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
  localparam int MAXP   = (MAX_SA > MAX_HR) ? MAX_SA : MAX_HR;
  localparam int CW     = $clog2(MAXP) + 1;
  localparam int HALF   = CLK_DIV / 2;
  localparam int DW     = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [2:0] {
    RST_HOLD, IDLE, SETUP, ACCESS, HOLD, UNMAPPED
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;     // shared phase counter, reloaded with N-1 on entry
  logic            we_q;
  logic [DW-1:0]   div_cnt;

  wire is_rom = ~req_addr[15];
  wire is_ram = (req_addr[15:13] == 3'b101);

  // Free-running PHI divider; phase deliberately unrelated to transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      cart_clk <= 1'b0;
    end else if (div_cnt == DW'(HALF - 1)) begin
      div_cnt  <= '0;
      cart_clk <= ~cart_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_HOLD;
      cnt        <= CW'(RST_CYC - 1);
      we_q       <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      cart_n_rst <= 1'b0;
      cart_n_cs  <= 1'b1;
      cart_n_rd  <= 1'b1;
      cart_n_wr  <= 1'b1;
      cart_addr  <= '0;
      cart_d_out <= '0;
      cart_d_oe  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        RST_HOLD: begin
          if (cnt == '0) begin
            cart_n_rst <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            if (is_rom || is_ram) begin
              cart_addr <= req_addr;
              cart_n_cs <= ~is_ram;
              if (req_we) begin
                cart_d_out <= req_wdata;
                cart_d_oe  <= 1'b1;
              end
              cnt   <= CW'(SETUP_CYC - 1);
              state <= SETUP;
            end else begin
              state <= UNMAPPED;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            // Only the strobe matching the direction goes low, so /RD never
            // overlaps an FPGA-driven data bus.
            cart_n_rd <= we_q;
            cart_n_wr <= ~we_q;
            cnt       <= CW'(ACCESS_CYC - 1);
            state     <= ACCESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) rsp_rdata <= cart_d_in;
            cart_n_rd <= 1'b1;
            cart_n_wr <= 1'b1;
            rsp_valid <= 1'b1;
            cnt       <= CW'(HOLD_CYC - 1);
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cart_n_cs <= 1'b1;
            cart_d_oe <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        UNMAPPED: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= 8'hFF;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: doc/cart_bus_ctrl.md
Name: cart_bus_ctrl

Overview:
- Bridges MMU cartridge accesses (ROM 0x0000–0x7FFF, external RAM 0xA000–0xBFFF) to the physical Game Boy cartridge edge connector on the PMOD headers.
- Sequences the cartridge power-on reset, the address, /RD, /WR and /CS timing, and the data-bus direction. It also generates the cartridge clock.
- Sits directly upstream of the MMU ROM port and replaces the on-chip ROM BRAM when a real cartridge is fitted.
- Top level maps the pins: cart_addr to jd/jb; cart_n_rst, cart_n_cs, cart_n_rd, cart_n_wr and cart_clk to jc; the tristate for ja is built from cart_d_out/cart_d_oe.

Parameters:
- SETUP_CYC, 1: cycles the address is stable before the strobe (>=1).
- ACCESS_CYC, 2: cycles /RD or /WR is held low (>=1).
- HOLD_CYC, 1: cycles address/data are held after the strobe is released (>=1).
- RST_CYC, 16: cycles cart_n_rst is held low after rst deasserts (>=1).
- CLK_DIV, 4: cart_clk period in clk cycles (even, >=2).

Ports:
- clk  in  1  system clock (4 MHz domain)
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MMU request strobe
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  CPU address
- req_wdata  in  8  write data
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  8  read data, valid while rsp_valid
- cart_clk  out  1  cartridge PHI clock
- cart_n_rst  out  1  cartridge reset, active low
- cart_n_cs  out  1  external RAM chip select, active low
- cart_n_rd  out  1  read strobe, active low
- cart_n_wr  out  1  write strobe, active low
- cart_addr  out  16  cartridge address bus
- cart_d_out  out  8  data driven to the cartridge
- cart_d_oe  out  1  1 = FPGA drives the data bus
- cart_d_in  in  8  data sampled from the cartridge

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high and overrides everything, including a transaction in flight. On a reset the transaction is dropped and no rsp_valid is issued.
- Reset values: cart_n_rst=0, cart_n_cs=1, cart_n_rd=1, cart_n_wr=1, cart_addr=0, cart_d_out=0, cart_d_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0, cart_clk=0. State goes to RST_HOLD.
- cart_clk: free-running divider that toggles every CLK_DIV/2 cycles. It is forced to 0 during rst.
- req_ready = (state==IDLE). All pin outputs are registered.
- RST_HOLD: counts RST_CYC cycles with cart_n_rst=0, then sets cart_n_rst=1 and goes to IDLE.
- IDLE: all strobes high, cart_d_oe=0. On accept, latch addr/we/wdata and classify the address:
  - ROM (0x0000–0x7FFF) or RAM (0xA000–0xBFFF): drive cart_addr. cart_n_cs=0 only for the RAM range. For a write, set cart_d_out=wdata and cart_d_oe=1. Go to SETUP.
  - Any other address: no pin activity. Go to UNMAPPED.
- SETUP: SETUP_CYC cycles, then go to ACCESS.
- ACCESS: ACCESS_CYC cycles with cart_n_rd=0 (read) or cart_n_wr=0 (write). On a read, rsp_rdata captures cart_d_in at the final ACCESS edge. Then go to HOLD.
- HOLD: strobes high, cart_addr/cart_n_cs/cart_d_oe unchanged.
  - rsp_valid=1 in the first HOLD cycle only.
  - For a write, rsp_rdata keeps its previous value.
  - After HOLD_CYC cycles: cart_n_cs=1, cart_d_oe=0, go to IDLE.
- UNMAPPED: one cycle with rsp_valid=1 and rsp_rdata=0xFF (writes discarded), then go to IDLE.
- Latency: rsp_valid is high SETUP_CYC+ACCESS_CYC cycles after the accept edge (3 with defaults). The next accept is possible SETUP_CYC+ACCESS_CYC+HOLD_CYC+1 cycles after accept (5 with defaults). UNMAPPED gives rsp_valid at +1, with the next accept at +2.
- Busy: req_valid outside IDLE is ignored. The requester holds its request; nothing is queued.
- Writes into 0x0000–0x7FFF (MBC bank registers) are normal write cycles with cart_n_cs=1.
- Bus safety: cart_d_oe and cart_n_rd=0 are never asserted in the same cycle.
- Phase: cart_clk phase is not synchronised to transactions.
- Counters: a single down-counter of width clog2(max param)+1, reloaded on each state entry.

Test Plan:
- Release rst -> cart_n_rst low exactly 16 cycles, then high. req_ready rises the same cycle. cart_clk has a period of 4 cycles.
- Read 0x0134 with cart_d_in=0x54 -> cart_addr=0x0134, cart_n_cs=1, cart_n_rd low 2 cycles, rsp_valid at accept+3 with rsp_rdata=0x54, req_ready back at accept+5.
- Write 0xA010=0x5A -> cart_n_cs=0 and cart_d_oe=1 from accept+1 through HOLD, cart_d_out=0x5A, cart_n_wr low 2 cycles, cart_n_rd never low, rsp_valid at +3.
- Read 0xC000 -> no pin change, rsp_valid at +1 with rsp_rdata=0xFF. Write 0xFF40 -> ack at +1, no pin activity.
- Second req_valid held during a busy read -> not accepted until IDLE. Second address sampled only then; exactly two rsp_valid pulses.
- rst asserted during ACCESS of a RAM write -> next cycle cart_n_wr=1, cart_d_oe=0, cart_n_cs=1, cart_n_rst=0, no rsp_valid. After rst deasserts, the full 16-cycle reset hold repeats.
